// File: rtl/core_if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Widths, reset PC, NOP encoding, ibuf entry layout and the fetch FSM state type.
package core_if_fetch_pkg;

   localparam int CORE_XLEN       = 32;
   localparam int CORE_INST_WIDTH = 32;
   localparam int IFU_ENTRY_W     = CORE_INST_WIDTH + CORE_XLEN + 1;

   localparam logic [CORE_XLEN-1:0]       CORE_RESET_PC = 32'h8000_0000;
   localparam logic [CORE_INST_WIDTH-1:0] CORE_INST_NOP = 32'h0000_0013;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [CORE_INST_WIDTH-1:0] inst;
      logic [CORE_XLEN-1:0]       pc;
      logic                       err;
   } ifu_entry_t;

   function automatic logic [CORE_XLEN-1:0] align_word(input logic [CORE_XLEN-1:0] a);
      return a & ~CORE_XLEN'(3);
   endfunction

endpackage

// File: rtl/core_if_ibuf.sv
// Small synchronous FIFO with flush; holds both fetched entries and request PC tags.
// DEPTH must be a power of two so the pointers wrap naturally.
module core_if_ibuf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   input  logic             flush,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & (count != CW'(DEPTH));
   assign pop_ok  = pop & (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage needs no reset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/core_if_fetch.sv
// Instruction fetch stage: owns the fetch PC, credit-limits memory requests and
// buffers in-order responses for ID. Optional misaligned-redirect fault: CORE_IF_MISALIGN_CHK_EN.
module core_if_fetch
   import core_if_fetch_pkg::*;
#(
   parameter logic [CORE_XLEN-1:0] RESET_PC   = CORE_RESET_PC,
   parameter int                   IBUF_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       o_ifu_req_valid,
   input  logic                       i_ifu_req_ready,
   output logic [CORE_XLEN-1:0]       o_ifu_req_addr,
   input  logic                       i_ifu_rsp_valid,
   input  logic [CORE_INST_WIDTH-1:0] i_ifu_rsp_inst,
   input  logic                       i_ifu_rsp_err,
   input  logic                       i_redirect_valid,
   input  logic [CORE_XLEN-1:0]       i_redirect_pc,
   output logic                       o_id_valid,
   input  logic                       i_id_ready,
   output logic [CORE_INST_WIDTH-1:0] o_id_inst,
   output logic [CORE_XLEN-1:0]       o_id_pc,
   output logic                       o_id_err,
   output fetch_state_e               o_dbg_state
);

   // Handshakes: a transfer happens on a cycle where valid & ready are both high;
   // valid never depends on ready, and a redirect withdraws both the request and the ID entry.
   localparam int CW = $clog2(IBUF_DEPTH) + 1;
   localparam int SW = CW + 1;

   fetch_state_e         state_q, state_d;
   logic [CORE_XLEN-1:0] fetch_pc_q;
   logic [CW-1:0]        outstanding_q, outstanding_d;
   logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]        ibuf_count;
   logic [CW-1:0]        tag_count;
   logic [CORE_XLEN-1:0] tag_pc;
   logic [SW-1:0]        credits;
   logic                 credit_ok;
   logic                 req_fire;
   logic                 rsp_keep;
   logic                 fault_push;
   logic                 fault_stall;
   logic [CORE_XLEN-1:0] redirect_target;
   ifu_entry_t           ibuf_din;
   ifu_entry_t           ibuf_dout;

   assign credits   = SW'(ibuf_count) + SW'(outstanding_q);
   assign credit_ok = credits < SW'(IBUF_DEPTH);

   assign o_ifu_req_valid = rst_n & (state_q == FETCH_RUN) & credit_ok
                          & ~i_redirect_valid & ~fault_stall;
   assign o_ifu_req_addr  = align_word(fetch_pc_q);
   assign req_fire        = o_ifu_req_valid & i_ifu_req_ready;

   // Responses arriving during a drain or alongside a redirect belong to a dead stream.
   assign rsp_keep = i_ifu_rsp_valid & (drop_cnt_q == '0) & ~i_redirect_valid
                   & (tag_count != '0);

   assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_ifu_rsp_valid);

`ifdef CORE_IF_MISALIGN_CHK_EN
   logic fault_pend_q;
   logic fault_stall_q;

   assign redirect_target = i_redirect_pc;
   assign fault_stall     = fault_stall_q;
   assign fault_push      = fault_pend_q & (state_q == FETCH_RUN)
                          & ~i_redirect_valid & ~i_ifu_rsp_valid;

   // A misaligned target parks fetch; one faulting NOP goes to ID once the old stream drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_pend_q  <= 1'b0;
         fault_stall_q <= 1'b0;
      end else if (i_redirect_valid) begin
         fault_pend_q  <= |i_redirect_pc[1:0];
         fault_stall_q <= |i_redirect_pc[1:0];
      end else if (fault_push) begin
         fault_pend_q  <= 1'b0;
      end
   end
`else
   assign redirect_target = align_word(i_redirect_pc);
   assign fault_stall     = 1'b0;
   assign fault_push      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      if (i_redirect_valid) begin
         drop_cnt_d = outstanding_q - CW'(i_ifu_rsp_valid);
      end else if (i_ifu_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end
      case (state_q)
         FETCH_RUN:   if (i_redirect_valid && (drop_cnt_d != '0)) state_d = FETCH_DRAIN;
         FETCH_DRAIN: if (drop_cnt_d == '0) state_d = FETCH_RUN;
         default:     state_d = FETCH_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH_RUN;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         if (i_redirect_valid)  fetch_pc_q <= redirect_target;
         else if (req_fire)     fetch_pc_q <= fetch_pc_q + CORE_XLEN'(4);
      end
   end

   always_comb begin
      ibuf_din = {CORE_INST_NOP, fetch_pc_q, 1'b1};
      if (rsp_keep) ibuf_din = {i_ifu_rsp_inst, tag_pc, i_ifu_rsp_err};
   end

   core_if_ibuf #(.DEPTH(IBUF_DEPTH), .WIDTH(CORE_XLEN)) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_fire),
      .din   (o_ifu_req_addr),
      .pop   (rsp_keep),
      .dout  (tag_pc),
      .flush (i_redirect_valid),
      .count (tag_count)
   );

   core_if_ibuf #(.DEPTH(IBUF_DEPTH), .WIDTH(IFU_ENTRY_W)) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_keep | fault_push),
      .din   (ibuf_din),
      .pop   (o_id_valid & i_id_ready),
      .dout  (ibuf_dout),
      .flush (i_redirect_valid),
      .count (ibuf_count)
   );

   assign o_id_valid  = (ibuf_count != '0) & ~i_redirect_valid;
   assign o_id_inst   = ibuf_dout.inst;
   assign o_id_pc     = ibuf_dout.pc;
   assign o_id_err    = ibuf_dout.err;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_core_if_fetch.sv
// Scoreboard bench for core_if_fetch: randomized memory/ID/redirect traffic against a
// stream-level model (PC counter per redirect epoch, in-order memory queue).
module tb_core_if_fetch;
   import core_if_fetch_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         o_ifu_req_valid;
   logic         i_ifu_req_ready;
   logic [31:0]  o_ifu_req_addr;
   logic         i_ifu_rsp_valid;
   logic [31:0]  i_ifu_rsp_inst;
   logic         i_ifu_rsp_err;
   logic         i_redirect_valid;
   logic [31:0]  i_redirect_pc;
   logic         o_id_valid;
   logic         i_id_ready;
   logic [31:0]  o_id_inst;
   logic [31:0]  o_id_pc;
   logic         o_id_err;
   fetch_state_e o_dbg_state;

   core_if_fetch #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_ifu_req_valid  (o_ifu_req_valid),
      .i_ifu_req_ready  (i_ifu_req_ready),
      .o_ifu_req_addr   (o_ifu_req_addr),
      .i_ifu_rsp_valid  (i_ifu_rsp_valid),
      .i_ifu_rsp_inst   (i_ifu_rsp_inst),
      .i_ifu_rsp_err    (i_ifu_rsp_err),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_id_valid       (o_id_valid),
      .i_id_ready       (i_id_ready),
      .o_id_inst        (o_id_inst),
      .o_id_pc          (o_id_pc),
      .o_id_err         (o_id_err),
      .o_dbg_state      (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- model and scoreboard state ----------------
   logic [64:0] exp_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] model_pc;
   logic        model_stall;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          first_id = -1;
   int          req_cnt = 0;
   logic [31:0] first_req;
   int          req_prob, rsp_prob, id_prob;
   logic        rand_redir;
   logic        redir_req;
   logic [31:0] redir_pc;

   function automatic logic [31:0] inst_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   function automatic logic err_f(input logic [31:0] a);
      return a[6:2] == 5'd1;
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver: one clock cycle of stimulus + request-side model ----------------
   task automatic cycle();
      logic [31:0] tgt;
      i_ifu_req_ready = ($urandom_range(0, 99) < req_prob);
      i_id_ready      = ($urandom_range(0, 99) < id_prob);
      if (mem_q.size() != 0 && $urandom_range(0, 99) < rsp_prob) begin
         i_ifu_rsp_valid = 1'b1;
         i_ifu_rsp_inst  = inst_f(mem_q[0]);
         i_ifu_rsp_err   = err_f(mem_q[0]);
      end else begin
         i_ifu_rsp_valid = 1'b0;
         i_ifu_rsp_inst  = $urandom;
         i_ifu_rsp_err   = 1'b0;
      end
      if (redir_req) begin
         i_redirect_valid = 1'b1;
         i_redirect_pc    = redir_pc;
         redir_req        = 1'b0;
      end else if (rand_redir && $urandom_range(0, 99) < 4) begin
         tgt = RPC + ($urandom_range(0, 63) << 2);
         if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         i_redirect_valid = 1'b1;
         i_redirect_pc    = tgt;
      end else begin
         i_redirect_valid = 1'b0;
         i_redirect_pc    = $urandom;
      end
      #4;
      if (o_id_valid && first_id < 0) first_id = cyc;
      if (i_ifu_rsp_valid) void'(mem_q.pop_front());
      if (o_ifu_req_valid && i_ifu_req_ready) begin
         req_cnt++;
         if (req_cnt == 1) first_req = o_ifu_req_addr;
         chk("req_addr", 65'(o_ifu_req_addr), 65'(model_pc));
         chk("req_while_stalled", 65'(model_stall), 65'(0));
         mem_q.push_back(o_ifu_req_addr);
         chk("outstanding_bound", 65'(mem_q.size() <= DEPTH), 65'(1));
         exp_q.push_back({inst_f(model_pc), model_pc, err_f(model_pc)});
         model_pc = model_pc + 32'd4;
      end
      if (i_redirect_valid) begin
         chk("req_gated_on_redirect", 65'(o_ifu_req_valid), 65'(0));
         exp_q.delete();
`ifdef CORE_IF_MISALIGN_CHK_EN
         model_pc    = i_redirect_pc;
         model_stall = (i_redirect_pc[1:0] != 2'b00);
         if (model_stall) exp_q.push_back({32'h0000_0013, i_redirect_pc, 1'b1});
`else
         model_pc    = {i_redirect_pc[31:2], 2'b00};
         model_stall = 1'b0;
`endif
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect(input logic [31:0] pc);
      redir_req = 1'b1;
      redir_pc  = pc;
      cycle();
   endtask

   // ---------------- monitor: pops expected entries as ID consumes ----------------
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n === 1'b1) begin
            if (i_redirect_valid) begin
               chk("id_valid_gated", 65'(o_id_valid), 65'(0));
            end else if (o_id_valid && i_id_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL id_unexpected actual pc=%h inst=%h expected none", o_id_pc, o_id_inst);
               end else begin
                  e = exp_q.pop_front();
                  chk("id_entry", {o_id_inst, o_id_pc, o_id_err}, e);
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b0; i_ifu_rsp_inst = '0; i_ifu_rsp_err = 1'b0;
      i_redirect_valid = 1'b0; i_redirect_pc = '0; i_id_ready = 1'b0;
      model_pc = RPC; model_stall = 1'b0; first_req = '0;
      req_prob = 100; rsp_prob = 100; id_prob = 100; rand_redir = 1'b0; redir_req = 1'b0; redir_pc = '0;
      repeat (3) @(negedge clk);
      #4;
      chk("reset_req_valid", 65'(o_ifu_req_valid), 65'(0));
      chk("reset_id_valid", 65'(o_id_valid), 65'(0));
      chk("reset_state", 65'(o_dbg_state), 65'(FETCH_RUN));
      @(negedge clk);
      rst_n = 1'b1;

      // streaming with a 1-cycle memory; 8000_0004 returns a bus error
      run(16);
      chk("first_id_latency", 65'(first_id), 65'(2));

      // ID stalled: fetch must stop after DEPTH requests
      id_prob = 0;
      req_cnt = 0;
      redirect(RPC + 32'h200);
      run(12);
      chk("stall_req_count", 65'(req_cnt), 65'(DEPTH));
      chk("stall_req_valid", 65'(o_ifu_req_valid), 65'(0));
      id_prob = 100;
      run(10);

      // two requests in flight, redirect drops both
      rsp_prob = 0;
      run(6);
      chk("two_in_flight", 65'(mem_q.size()), 65'(2));
      req_cnt = 0;
      redirect(RPC + 32'h100);
      chk("drain_state", 65'(o_dbg_state), 65'(FETCH_DRAIN));
      rsp_prob = 100;
      run(12);
      chk("redirect_first_req", 65'(first_req), 65'(RPC + 32'h100));

      // redirect coincident with a response, then a second redirect mid-drain
      rsp_prob = 0;
      run(6);
      rsp_prob = 100;
      redirect(RPC + 32'h200);
      rsp_prob = 0;
      cycle();
      req_cnt = 0;
      redirect(RPC + 32'h300);
      chk("drain_after_second", 65'(o_dbg_state), 65'(FETCH_DRAIN));
      rsp_prob = 100;
      run(12);
      chk("second_target_req", 65'(first_req), 65'(RPC + 32'h300));

      // misaligned redirect target
      req_cnt = 0;
      redirect(RPC + 32'h102);
      run(8);
`ifdef CORE_IF_MISALIGN_CHK_EN
      chk("misalign_no_req", 65'(req_cnt), 65'(0));
      redirect(RPC + 32'h40);
`else
      chk("misalign_first_req", 65'(first_req), 65'(RPC + 32'h100));
`endif
      run(6);

      // randomized traffic
      req_prob = 70; rsp_prob = 70; id_prob = 70; rand_redir = 1'b1;
      run(800);

      // drain everything still expected
      rand_redir = 1'b0; req_prob = 0; rsp_prob = 100; id_prob = 100;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || mem_q.size() != 0); i++) cycle();
      chk("final_drain", 65'(exp_q.size()), 65'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
